// File: rtl/pkt_fifo_wr_ctrl.sv
// Packet FIFO write controller: hunts for one of two header words, then forwards
// PKT_LEN payload words to the downstream FIFO, dropping the packet on backpressure.
module pkt_fifo_wr_ctrl #(
  parameter int unsigned       WORD_W      = 8,
  parameter logic [WORD_W-1:0] HDR_A       = 8'hA5,
  parameter logic [WORD_W-1:0] HDR_B       = 8'hC3,
  parameter int unsigned       PKT_LEN     = 4,
  parameter int unsigned       INCLUDE_HDR = 0,
  parameter int unsigned       DROP_CNT_W  = 8
) (
  input  logic                  clk_50,
  input  logic                  reset_n,
  input  logic                  data_ena,
  input  logic                  word_valid,
  input  logic [WORD_W-1:0]     word_in,
  input  logic                  fifo_full,
  output logic                  wr,
  output logic [WORD_W-1:0]     wr_data,
  output logic                  pkt_done,
  output logic                  hdr_sel,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam logic [7:0]            LAST_IDX = 8'(PKT_LEN - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);

  state_t                state_r, state_s;
  logic [7:0]            cnt_r, cnt_s;
  logic                  wr_r, wr_s;
  logic [WORD_W-1:0]     wr_data_r, wr_data_s;
  logic                  pkt_done_r, pkt_done_s;
  logic                  hdr_sel_r, hdr_sel_s;
  logic                  busy_r, busy_s;
  logic [DROP_CNT_W-1:0] drop_cnt_r, drop_cnt_s;
  logic                  drop_inc_s;
  logic                  accept_s;
  logic                  hdr_hit_s;
  logic                  last_s;

  assign accept_s  = word_valid & data_ena;
  assign hdr_hit_s = (word_in == HDR_A) || (word_in == HDR_B);
  assign last_s    = (cnt_r == LAST_IDX);

  // State register and registered outputs
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_HUNT;
      cnt_r      <= 8'd0;
      wr_r       <= 1'b0;
      wr_data_r  <= '0;
      pkt_done_r <= 1'b0;
      hdr_sel_r  <= 1'b0;
      busy_r     <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      wr_r       <= wr_s;
      wr_data_r  <= wr_data_s;
      pkt_done_r <= pkt_done_s;
      hdr_sel_r  <= hdr_sel_s;
      busy_r     <= busy_s;
      drop_cnt_r <= drop_cnt_s;
    end
  end

  // Next-state, counter and next-output decode
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    wr_s       = 1'b0;
    wr_data_s  = wr_data_r;
    pkt_done_s = 1'b0;
    hdr_sel_s  = hdr_sel_r;
    drop_inc_s = 1'b0;

    case (state_r)
      ST_HUNT: begin
        if (accept_s && hdr_hit_s) begin
          hdr_sel_s = (word_in != HDR_A);
          cnt_s     = 8'd0;
          if (INCLUDE_HDR != 0) begin
            if (fifo_full) begin
              state_s    = ST_DROP;
              drop_inc_s = 1'b1;
            end else begin
              state_s   = ST_PAYLOAD;
              wr_s      = 1'b1;
              wr_data_s = word_in;
            end
          end else begin
            state_s = ST_PAYLOAD;
          end
        end else begin
          state_s = ST_HUNT;
        end
      end

      ST_PAYLOAD: begin
        if (!data_ena) begin
          state_s = ST_HUNT;
          cnt_s   = 8'd0;
        end else if (word_valid) begin
          if (!fifo_full) begin
            wr_s      = 1'b1;
            wr_data_s = word_in;
          end else begin
            drop_inc_s = 1'b1;
          end
          if (last_s) begin
            // A full FIFO on the last word still ends the packet, just without pkt_done
            pkt_done_s = ~fifo_full;
            state_s    = ST_HUNT;
            cnt_s      = 8'd0;
          end else begin
            cnt_s   = cnt_r + 8'd1;
            state_s = fifo_full ? ST_DROP : ST_PAYLOAD;
          end
        end else begin
          state_s = ST_PAYLOAD;
        end
      end

      ST_DROP: begin
        if (!data_ena) begin
          state_s = ST_HUNT;
          cnt_s   = 8'd0;
        end else if (word_valid) begin
          if (last_s) begin
            state_s = ST_HUNT;
            cnt_s   = 8'd0;
          end else begin
            state_s = ST_DROP;
            cnt_s   = cnt_r + 8'd1;
          end
        end else begin
          state_s = ST_DROP;
        end
      end

      default: begin
        state_s = ST_HUNT;
        cnt_s   = 8'd0;
      end
    endcase

    busy_s = (state_s == ST_PAYLOAD) || (state_s == ST_DROP);

    if (drop_inc_s && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_s = drop_cnt_r + DROP_ONE;
    end else begin
      drop_cnt_s = drop_cnt_r;
    end
  end

  assign wr       = wr_r;
  assign wr_data  = wr_data_r;
  assign pkt_done = pkt_done_r;
  assign hdr_sel  = hdr_sel_r;
  assign busy     = busy_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_pkt_fifo_wr_ctrl.sv
// Directed, table-driven bench for pkt_fifo_wr_ctrl: three parameterisations share
// one input stream; each vector names which instance it checks.
module tb_pkt_fifo_wr_ctrl;

  logic       clk_50 = 1'b0;
  logic       reset_n;
  logic       data_ena;
  logic       word_valid;
  logic [7:0] word_in;
  logic       fifo_full;

  logic       wr0, done0, hdr0, busy0;
  logic [7:0] data0, drop0;
  logic       wr1, done1, hdr1, busy1;
  logic [7:0] data1, drop1;
  logic       wr2, done2, hdr2, busy2;
  logic [7:0] data2;
  logic [1:0] drop2;

  always #10 clk_50 = ~clk_50;

  pkt_fifo_wr_ctrl u_dut_def (
    .clk_50(clk_50), .reset_n(reset_n), .data_ena(data_ena), .word_valid(word_valid),
    .word_in(word_in), .fifo_full(fifo_full), .wr(wr0), .wr_data(data0),
    .pkt_done(done0), .hdr_sel(hdr0), .busy(busy0), .drop_cnt(drop0));

  pkt_fifo_wr_ctrl #(.INCLUDE_HDR(1)) u_dut_hdr (
    .clk_50(clk_50), .reset_n(reset_n), .data_ena(data_ena), .word_valid(word_valid),
    .word_in(word_in), .fifo_full(fifo_full), .wr(wr1), .wr_data(data1),
    .pkt_done(done1), .hdr_sel(hdr1), .busy(busy1), .drop_cnt(drop1));

  pkt_fifo_wr_ctrl #(.DROP_CNT_W(2)) u_dut_sat (
    .clk_50(clk_50), .reset_n(reset_n), .data_ena(data_ena), .word_valid(word_valid),
    .word_in(word_in), .fifo_full(fifo_full), .wr(wr2), .wr_data(data2),
    .pkt_done(done2), .hdr_sel(hdr2), .busy(busy2), .drop_cnt(drop2));

  int         sel;
  logic       c_wr, c_done, c_hdr, c_busy;
  logic [7:0] c_data, c_drop;

  always_comb begin
    c_wr = wr0; c_data = data0; c_done = done0; c_hdr = hdr0; c_busy = busy0; c_drop = drop0;
    case (sel)
      1: begin
        c_wr = wr1; c_data = data1; c_done = done1; c_hdr = hdr1; c_busy = busy1; c_drop = drop1;
      end
      2: begin
        c_wr = wr2; c_data = data2; c_done = done2; c_hdr = hdr2; c_busy = busy2;
        c_drop = {6'd0, drop2};
      end
      default: ;
    endcase
  end

  typedef struct {
    int         sel;
    logic       ena;
    logic       valid;
    logic [7:0] word;
    logic       full;
    logic       wr;
    logic [7:0] data;
    logic       done;
    logic       hdr;
    logic       busy;
    logic [7:0] drop;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int s, logic ena, logic valid, logic [7:0] word, logic full,
                              logic ewr, logic [7:0] edata, logic edone, logic ehdr,
                              logic ebusy, logic [7:0] edrop);
    vec_t v;
    v.sel = s; v.ena = ena; v.valid = valid; v.word = word; v.full = full;
    v.wr = ewr; v.data = edata; v.done = edone; v.hdr = ehdr; v.busy = ebusy; v.drop = edrop;
    vq.push_back(v);
  endfunction

  task automatic check_all_zero(input string name);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (c_wr !== 1'b0 || c_data !== 8'h00 || c_done !== 1'b0 || c_hdr !== 1'b0 ||
          c_busy !== 1'b0 || c_drop !== 8'h00) begin
        errors++;
        $display("FAIL %s dut%0d: got wr=%b data=%h done=%b hdr=%b busy=%b drop=%0d, want all 0",
                 name, s, c_wr, c_data, c_done, c_hdr, c_busy, c_drop);
      end
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk_50);
    reset_n = 1'b0; data_ena = 1'b1; word_valid = 1'b0; word_in = 8'h00; fifo_full = 1'b0;
    check_all_zero(name);
    @(negedge clk_50);
    reset_n = 1'b1;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge
  task automatic run_vecs(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_50);
      sel = vq[i].sel; data_ena = vq[i].ena; word_valid = vq[i].valid;
      word_in = vq[i].word; fifo_full = vq[i].full;
      @(posedge clk_50);
      #1;
      checks++;
      if (c_wr !== vq[i].wr || c_done !== vq[i].done || c_hdr !== vq[i].hdr ||
          c_busy !== vq[i].busy || c_drop !== vq[i].drop ||
          (vq[i].wr && c_data !== vq[i].data)) begin
        errors++;
        $display("FAIL %s row %0d: got wr=%b data=%h done=%b hdr=%b busy=%b drop=%0d, want wr=%b data=%h done=%b hdr=%b busy=%b drop=%0d",
                 name, i, c_wr, c_data, c_done, c_hdr, c_busy, c_drop,
                 vq[i].wr, vq[i].data, vq[i].done, vq[i].hdr, vq[i].busy, vq[i].drop);
      end
    end
    vq.delete();
  endtask

  initial begin
    sel = 0; reset_n = 1'b0; data_ena = 1'b0; word_valid = 1'b0; word_in = 8'h00; fifo_full = 1'b0;
    #5;
    check_all_zero("por");

    // Basic packet on defaults; non-headers around it never written
    do_reset("reset1");
    //  sel ena val word  full  wr data   done hdr busy drop
    add(0, 1, 1, 8'h11, 0,    0, 8'h00, 0, 0, 0, 8'd0);
    add(0, 1, 1, 8'hA5, 0,    0, 8'h00, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h01, 0,    1, 8'h01, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h02, 0,    1, 8'h02, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h03, 0,    1, 8'h03, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h04, 0,    1, 8'h04, 1, 0, 0, 8'd0);
    add(0, 1, 1, 8'h22, 0,    0, 8'h00, 0, 0, 0, 8'd0);
    run_vecs("basic");

    // INCLUDE_HDR=1 with HDR_B
    do_reset("reset2");
    add(1, 1, 1, 8'hC3, 0,    1, 8'hC3, 0, 1, 1, 8'd0);
    add(1, 1, 1, 8'hAA, 0,    1, 8'hAA, 0, 1, 1, 8'd0);
    add(1, 1, 1, 8'hBB, 0,    1, 8'hBB, 0, 1, 1, 8'd0);
    add(1, 1, 1, 8'hCC, 0,    1, 8'hCC, 0, 1, 1, 8'd0);
    add(1, 1, 1, 8'hDD, 0,    1, 8'hDD, 1, 1, 0, 8'd0);
    add(1, 1, 0, 8'h00, 0,    0, 8'h00, 0, 1, 0, 8'd0);
    run_vecs("inc_hdr");

    // INCLUDE_HDR=1 with a full FIFO on the header drops the whole packet
    add(1, 1, 1, 8'hA5, 1,    0, 8'h00, 0, 0, 1, 8'd1);
    add(1, 1, 1, 8'h01, 0,    0, 8'h00, 0, 0, 1, 8'd1);
    add(1, 1, 1, 8'h02, 0,    0, 8'h00, 0, 0, 1, 8'd1);
    add(1, 1, 1, 8'h03, 0,    0, 8'h00, 0, 0, 1, 8'd1);
    add(1, 1, 1, 8'h04, 0,    0, 8'h00, 0, 0, 0, 8'd1);
    run_vecs("hdr_full");

    // Backpressure mid-packet, then a clean packet
    do_reset("reset3");
    add(0, 1, 1, 8'hA5, 0,    0, 8'h00, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h01, 0,    1, 8'h01, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h02, 0,    1, 8'h02, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h03, 1,    0, 8'h00, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h04, 0,    0, 8'h00, 0, 0, 0, 8'd1);
    add(0, 1, 1, 8'hA5, 0,    0, 8'h00, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h05, 0,    1, 8'h05, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h06, 0,    1, 8'h06, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h07, 0,    1, 8'h07, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h08, 0,    1, 8'h08, 1, 0, 0, 8'd1);
    run_vecs("backpressure");

    // Full FIFO on the last payload word: counted, no pkt_done, straight to HUNT
    add(0, 1, 1, 8'hA5, 0,    0, 8'h00, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h01, 0,    1, 8'h01, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h02, 0,    1, 8'h02, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h03, 0,    1, 8'h03, 0, 0, 1, 8'd1);
    add(0, 1, 1, 8'h04, 1,    0, 8'h00, 0, 0, 0, 8'd2);
    run_vecs("full_last");

    // Enable loss mid-packet
    do_reset("reset4");
    add(0, 1, 1, 8'hA5, 0,    0, 8'h00, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h01, 0,    1, 8'h01, 0, 0, 1, 8'd0);
    add(0, 0, 1, 8'h02, 0,    0, 8'h00, 0, 0, 0, 8'd0);
    add(0, 0, 1, 8'h03, 0,    0, 8'h00, 0, 0, 0, 8'd0);
    add(0, 0, 0, 8'h00, 0,    0, 8'h00, 0, 0, 0, 8'd0);
    add(0, 1, 1, 8'h09, 0,    0, 8'h00, 0, 0, 0, 8'd0);
    add(0, 1, 1, 8'hA5, 0,    0, 8'h00, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h0A, 0,    1, 8'h0A, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h0B, 0,    1, 8'h0B, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h0C, 0,    1, 8'h0C, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h0D, 0,    1, 8'h0D, 1, 0, 0, 8'd0);
    run_vecs("ena_loss");

    // Saturating drop counter (2 bits): 1,2,3,3
    do_reset("reset5");
    for (int p = 0; p < 4; p++) begin
      logic [7:0] d;
      d = (p < 3) ? 8'(p + 1) : 8'd3;
      add(2, 1, 1, 8'hA5, 0,  0, 8'h00, 0, 0, 1, (p == 0) ? 8'd0 : 8'(p));
      add(2, 1, 1, 8'h01, 1,  0, 8'h00, 0, 0, 1, d);
      add(2, 1, 1, 8'h02, 0,  0, 8'h00, 0, 0, 1, d);
      add(2, 1, 1, 8'h03, 0,  0, 8'h00, 0, 0, 1, d);
      add(2, 1, 1, 8'h04, 0,  0, 8'h00, 0, 0, 0, d);
    end
    run_vecs("saturate");

    // Headers as payload, a valid gap, back-to-back header, then async reset mid-packet
    do_reset("reset6");
    add(0, 1, 1, 8'hA5, 0,    0, 8'h00, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'hA5, 0,    1, 8'hA5, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'hC3, 0,    1, 8'hC3, 0, 0, 1, 8'd0);
    add(0, 1, 0, 8'h77, 0,    0, 8'h00, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'hA5, 0,    1, 8'hA5, 0, 0, 1, 8'd0);
    add(0, 1, 1, 8'h01, 0,    1, 8'h01, 1, 0, 0, 8'd0);
    add(0, 1, 1, 8'hC3, 0,    0, 8'h00, 0, 1, 1, 8'd0);
    add(0, 1, 1, 8'h02, 0,    1, 8'h02, 0, 1, 1, 8'd0);
    run_vecs("hdr_in_payload");

    @(negedge clk_50);
    word_valid = 1'b1; word_in = 8'h03;
    #3;
    reset_n = 1'b0;
    check_all_zero("async_reset");
    @(negedge clk_50);
    reset_n = 1'b1; word_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_fifo_wr_ctrl.md
Name: pkt_fifo_wr_ctrl

Overview:
- Parametrised FIFO write controller for the 50 MHz domain.
- Consumes the deserialiser word stream and hunts for either of two header words.
- After a header, forwards exactly PKT_LEN payload words (optionally preceded by the header) into the downstream FIFO.
- Also handles FIFO backpressure by dropping the packet, handles enable loss mid-packet, and keeps a saturating drop count.

Parameters:
WORD_W, 8, width of input word and FIFO write data
HDR_A, 8'hA5, first header value (WORD_W bits)
HDR_B, 8'hC3, second header value (WORD_W bits)
PKT_LEN, 4, payload words per packet following header; legal range 1..255
INCLUDE_HDR, 0, 1 = header word is also written to FIFO before the payload
DROP_CNT_W, 8, width of dropped-packet counter

Ports:
clk_50  in  1  50 MHz clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
data_ena  in  1  global enable; low forces return to HUNT
word_valid  in  1  one-cycle strobe, word_in valid
word_in  in  WORD_W  word from deserialiser
fifo_full  in  1  downstream FIFO full, sampled same cycle as word_valid
wr  out  1  FIFO write strobe, registered
wr_data  out  WORD_W  FIFO write data, registered, valid when wr=1
pkt_done  out  1  one-cycle pulse coincident with wr of last payload word
hdr_sel  out  1  0 = HDR_A matched, 1 = HDR_B matched; latched at header acceptance
busy  out  1  high in PAYLOAD or DROP
drop_cnt  out  DROP_CNT_W  saturating count of dropped packets

Behaviour:
- Reset (async, reset_n=0): wr=0, wr_data=0, pkt_done=0, hdr_sel=0, busy=0, drop_cnt=0, state=HUNT, word counter=0.
- States: HUNT, PAYLOAD, DROP. busy is a registered decode of state (PAYLOAD or DROP).
- An accepted word is one with word_valid=1 and data_ena=1. Words with word_valid=0 are ignored in every state.
- HUNT:
  - Accepted word equal to HDR_A or HDR_B: latch hdr_sel, clear counter, go to PAYLOAD.
  - If INCLUDE_HDR=1 and fifo_full=0: wr=1 and wr_data=header next cycle.
  - If INCLUDE_HDR=1 and fifo_full=1: go to DROP instead of PAYLOAD and increment drop_cnt.
  - Any other word: stay in HUNT, no write.
- PAYLOAD, accepted word with fifo_full=0:
  - wr=1, wr_data=word_in next cycle; counter increments.
  - When counter reaches PKT_LEN-1 (last word): pkt_done=1 with that wr, go to HUNT.
  - Header values appearing inside the payload are treated as data.
- PAYLOAD, accepted word with fifo_full=1:
  - No write; drop_cnt+1 (saturating at all-ones); counter still increments; go to DROP.
  - If this was the last word, go straight to HUNT (drop still counted, no pkt_done).
- DROP: consume accepted words without writing until the counter reaches PKT_LEN-1, then go to HUNT. No pkt_done.
- data_ena=0 in PAYLOAD or DROP: next state HUNT, counter cleared, no write, no drop count. A partial packet already written is not retracted.
- Latency: exactly 1 clk_50 from accepted word to wr. Back-to-back word_valid on consecutive cycles must sustain one write per cycle.
- Header immediately following a completed packet (next cycle) must be detected. No dead cycle is allowed in HUNT.
- wr and pkt_done deassert the cycle after they pulse unless the next accepted word also writes.
- fifo_full is only checked on cycles with an accepted word.
- Reset asserted mid-packet: immediate return to reset values; partial packet abandoned.

Test Plan:
- Defaults, fifo_full=0, stream 11,A5,01,02,03,04,22 (valid every cycle) -> wr on 4 cycles with data 01,02,03,04; pkt_done with 04; hdr_sel=0; 11 and 22 never written.
- INCLUDE_HDR=1, stream C3,AA,BB,CC,DD -> writes C3,AA,BB,CC,DD; hdr_sel=1; pkt_done on DD.
- Defaults, stream A5,01,02 then fifo_full=1 on 03, then 04, then A5,05,06,07,08 with fifo_full=0 -> writes 01,02 then 05..08; drop_cnt=1; only one pkt_done (on 08).
- Defaults, A5,01, then data_ena=0 for 3 cycles carrying 02,03, then data_ena=1 with 09,A5,0A,0B,0C,0D -> writes 01 then 0A..0D; drop_cnt=0; 09 not written.
- DROP_CNT_W=2, four packets each hit fifo_full on the first payload word -> drop_cnt sequence 1,2,3,3 (saturates).
- Payload containing A5 (A5,A5,C3,A5,01) -> writes A5,C3,A5,01; single pkt_done; assert reset_n low mid-packet -> all outputs 0 on the same edge.
